// File: rtl/prefetch_queue_if.sv
// prefetch_queue_if
// -----------------------------------------------------------------------------
// Signal bundle between the instruction prefetch queue, the memory port and the
// control unit. clk and reset are not part of the bundle.
//
//   redirect     flush the queue and load a new fetch PC
//   redirect_pc  new fetch PC (bit 0 ignored)
//   mem_req      read request to memory
//   mem_addr     word-aligned read address
//   mem_ack      read data valid (may rise in the same cycle as mem_req)
//   mem_data     read data, sampled when mem_ack=1
//   ir_valid     head entry is valid
//   ir_data      head instruction word
//   ir_addr      address of the head word
//   ir_take      consumer pops the head this cycle
//   dbg_state    current fetch FSM state (0=IDLE, 1=REQ, 2=DRAIN)
//
// Handshakes: a memory read completes on a rising clock edge where
// mem_req=1 and mem_ack=1; once mem_req rises it stays high with mem_addr
// stable until that edge, and only one read is ever outstanding. A word leaves
// the queue on a rising edge where ir_valid=1 and ir_take=1; ir_take while
// ir_valid=0 has no effect.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

interface prefetch_queue_if;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_data;
    logic        ir_valid;
    logic [15:0] ir_data;
    logic [15:0] ir_addr;
    logic        ir_take;
    logic [1:0]  dbg_state;

    // The prefetch queue itself.
    modport slave (
        input  redirect,
        input  redirect_pc,
        input  mem_ack,
        input  mem_data,
        input  ir_take,
        output mem_req,
        output mem_addr,
        output ir_valid,
        output ir_data,
        output ir_addr,
        output dbg_state
    );

    // The surroundings: memory, control unit and redirect source.
    modport master (
        output redirect,
        output redirect_pc,
        output mem_ack,
        output mem_data,
        output ir_take,
        input  mem_req,
        input  mem_addr,
        input  ir_valid,
        input  ir_data,
        input  ir_addr,
        input  dbg_state
    );
endinterface

// File: rtl/prefetch_queue.sv
// prefetch_queue
// -----------------------------------------------------------------------------
// Instruction prefetch stage in front of the instruction register. Fetches
// sequential 16-bit words over a req/ack memory handshake into a small FIFO
// and presents the head word plus its address to the control unit. A redirect
// flushes the FIFO and restarts fetching at the new (word-aligned) PC.
//
// Ports:
//   clk    system clock, all state changes on the rising edge
//   reset  asynchronous, active-low reset
//   bus    prefetch_queue_if.slave: redirect/redirect_pc, memory req/ack port,
//          instruction head (ir_valid/ir_data/ir_addr/ir_take), dbg_state
//
// Parameters:
//   DEPTH  number of queue entries (power of two, at least 2)
//   PTRW   pointer width, log2(DEPTH)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module prefetch_queue #(
    parameter int DEPTH = 4,
    parameter int PTRW  = 2
) (
    input  logic            clk,
    input  logic            reset,
    prefetch_queue_if.slave bus
);

    // count must be able to represent DEPTH itself.
    localparam int            CW      = PTRW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic [15:0]     r_fetch_pc;
    logic [15:0]     r_req_addr;
    logic [CW-1:0]   r_count;
    logic [PTRW-1:0] r_rd_ptr;
    logic [PTRW-1:0] r_wr_ptr;

    logic [15:0]     r_entry_addr [DEPTH];
    logic [15:0]     r_entry_data [DEPTH];

    logic            w_push;
    logic            w_pop;
    logic            w_full;
    logic            w_ir_valid;
    logic            w_load_req;
    logic [CW-1:0]   w_count_nxt;
    logic [15:0]     w_fetch_pc_inc;
    logic [15:0]     w_req_addr_nxt;
    logic [15:0]     w_redirect_pc_al;

    // -------------------------------------------------------------------------
    // Queue bookkeeping
    // -------------------------------------------------------------------------
    assign w_full           = (r_count == DEPTH_C);
    assign w_ir_valid       = (r_count != '0);
    assign w_fetch_pc_inc   = r_fetch_pc + 16'd2;
    assign w_redirect_pc_al = bus.redirect_pc & 16'hFFFE;

    // Redirect wins over both a returning word and a pop: the whole queue is
    // discarded on that edge, so neither may move a pointer.
    assign w_push = (r_state == ST_REQ) && bus.mem_ack && !bus.redirect;
    assign w_pop  = bus.ir_take && w_ir_valid && !bus.redirect;

    assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);

    // -------------------------------------------------------------------------
    // Fetch FSM, next state
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_nxt    = r_state;
        w_load_req     = 1'b0;
        w_req_addr_nxt = r_fetch_pc;

        case (r_state)
            ST_IDLE: begin
                if (!bus.redirect && !w_full) begin
                    w_state_nxt = ST_REQ;
                    w_load_req  = 1'b1;
                end
            end

            ST_REQ: begin
                if (bus.redirect) begin
                    // A request is never withdrawn: without an ack we keep it
                    // up in DRAIN and throw the word away when it arrives.
                    w_state_nxt = bus.mem_ack ? ST_IDLE : ST_DRAIN;
                end else if (bus.mem_ack) begin
                    // Back-to-back issue uses the count after this edge's
                    // push and pop, so a simultaneous pop keeps streaming.
                    if (w_count_nxt != DEPTH_C) begin
                        w_state_nxt    = ST_REQ;
                        w_load_req     = 1'b1;
                        w_req_addr_nxt = w_fetch_pc_inc;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end

            ST_DRAIN: begin
                if (bus.mem_ack) begin
                    w_state_nxt = ST_IDLE;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_fetch_pc <= 16'h0000;
            r_req_addr <= 16'h0000;
            r_count    <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;

            // mem_addr has its own register so a redirect during DRAIN can
            // reload fetch_pc without disturbing the outstanding address.
            if (w_load_req) begin
                r_req_addr <= w_req_addr_nxt;
            end

            if (bus.redirect) begin
                r_fetch_pc <= w_redirect_pc_al;
                r_count    <= '0;
                r_rd_ptr   <= '0;
                r_wr_ptr   <= '0;
            end else begin
                if (w_push) begin
                    r_fetch_pc <= w_fetch_pc_inc;
                    r_wr_ptr   <= r_wr_ptr + PTRW'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + PTRW'(1);
                end
                r_count <= w_count_nxt;
            end
        end
    end

    // Entry storage needs no reset: the head is masked while count is zero.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_entry_addr[r_wr_ptr] <= r_fetch_pc;
            r_entry_data[r_wr_ptr] <= bus.mem_data;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    // mem_req is decoded straight from the state so it drops the moment reset
    // is asserted, without waiting for a clock edge.
    assign bus.mem_req   = (r_state != ST_IDLE);
    assign bus.mem_addr  = r_req_addr;
    assign bus.ir_valid  = w_ir_valid;
    assign bus.ir_data   = w_ir_valid ? r_entry_data[r_rd_ptr] : 16'h0000;
    assign bus.ir_addr   = w_ir_valid ? r_entry_addr[r_rd_ptr] : 16'h0000;
    assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_prefetch_queue.sv
`timescale 1ns/1ps

module tb_prefetch_queue;

    localparam int DEPTH = 4;

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    prefetch_queue_if bus ();

    prefetch_queue #(
        .DEPTH (DEPTH),
        .PTRW  (2)
    ) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    // ------------------------------------------------------------------
    // Bookkeeping
    // ------------------------------------------------------------------
    int checks = 0;
    int errors = 0;

    // Expected queue contents, {addr, data}, head at index 0.
    logic [31:0] exp_q[$];
    logic [15:0] model_pc;
    logic        stale;
    logic        prev_req;
    logic        prev_ack;
    logic [15:0] prev_addr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory contents: every word holds 0x1000 plus its own address.
    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return 16'h1000 + a;
    endfunction

    // ------------------------------------------------------------------
    // Memory responder: ack after a programmable number of wait cycles
    // ------------------------------------------------------------------
    int   ack_delay = 0;
    bit   rand_ack  = 1'b0;
    int   wait_cnt  = 0;
    int   cur_delay = 0;
    logic ack_r     = 1'b0;

    assign bus.mem_ack  = ack_r;
    assign bus.mem_data = mem_word(bus.mem_addr);

    always @(posedge clk) begin
        #1;
        if (!rst_n || !bus.mem_req) begin
            wait_cnt = 0;
            ack_r    = 1'b0;
        end else begin
            if (ack_r) wait_cnt = 0;   // previous request completed, new one
            wait_cnt++;
            if (wait_cnt == 1) cur_delay = rand_ack ? int'($urandom_range(0, 3)) : ack_delay;
            ack_r = (wait_cnt > cur_delay);
        end
    end

    // ------------------------------------------------------------------
    // Reference model: sequential instruction stream per redirect
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            model_pc  = 16'h0000;
            stale     = 1'b0;
            prev_req  = 1'b0;
            prev_ack  = 1'b0;
            prev_addr = 16'h0000;
        end else begin
            if (prev_req && !prev_ack && bus.mem_req)
                chk("addr_stable", 32'(bus.mem_addr), 32'(prev_addr));
            if (bus.mem_req && !stale)
                chk("req_addr", 32'(bus.mem_addr), 32'(model_pc));

            if (bus.redirect) begin
                // A read still in flight belongs to the old stream.
                stale    = bus.mem_req && !bus.mem_ack;
                exp_q.delete();
                model_pc = {bus.redirect_pc[15:1], 1'b0};
            end else begin
                if (bus.ir_take && exp_q.size() > 0) void'(exp_q.pop_front());
                if (bus.mem_req && bus.mem_ack) begin
                    if (stale) begin
                        stale = 1'b0;
                    end else begin
                        exp_q.push_back({model_pc, mem_word(model_pc)});
                        model_pc = model_pc + 16'd2;
                    end
                end
                chk("queue_bound", 32'(exp_q.size() <= DEPTH), 32'd1);
            end
            prev_req  = bus.mem_req;
            prev_ack  = bus.mem_ack;
            prev_addr = bus.mem_addr;
        end
    end

    // ------------------------------------------------------------------
    // Monitor: compare the presented head with the expected queue
    // ------------------------------------------------------------------
    always @(posedge clk) begin
        #2;
        if (rst_n) begin
            chk("ir_valid", 32'(bus.ir_valid), 32'(exp_q.size() != 0));
            if (exp_q.size() != 0) begin
                chk("ir_addr", 32'(bus.ir_addr), 32'(exp_q[0][31:16]));
                chk("ir_data", 32'(bus.ir_data), 32'(exp_q[0][15:0]));
            end
        end
    end

    // ------------------------------------------------------------------
    // Driver helpers
    // ------------------------------------------------------------------
    // Waits (bounded) for a cycle with mem_req=1; returns at posedge+2.
    task automatic wait_req(input string name);
        bit found = 1'b0;
        for (int n = 0; n < 30; n++) begin
            @(posedge clk); #2;
            if (bus.mem_req) begin found = 1'b1; break; end
        end
        chk(name, 32'(found), 32'd1);
    endtask

    // Waits (bounded) for a cycle with ir_valid=1; returns at posedge+2.
    task automatic wait_valid(input string name);
        bit found = 1'b0;
        for (int n = 0; n < 30; n++) begin
            @(posedge clk); #2;
            if (bus.ir_valid) begin found = 1'b1; break; end
        end
        chk(name, 32'(found), 32'd1);
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        logic [15:0] a;
        bit          found;

        bus.redirect    = 1'b0;
        bus.redirect_pc = 16'h0000;
        bus.ir_take     = 1'b0;
        rst_n           = 1'b0;

        // Reset values
        #12;
        chk("rst_mem_req",  32'(bus.mem_req),   32'd0);
        chk("rst_mem_addr", 32'(bus.mem_addr),  32'h0000);
        chk("rst_ir_valid", 32'(bus.ir_valid),  32'd0);
        chk("rst_ir_data",  32'(bus.ir_data),   32'h0000);
        chk("rst_ir_addr",  32'(bus.ir_addr),   32'h0000);
        chk("rst_state",    32'(bus.dbg_state), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Initial fill with combinational ack: four requests back to back
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #2;
            chk("fill_req",  32'(bus.mem_req),  32'd1);
            chk("fill_addr", 32'(bus.mem_addr), 32'(2 * i));
        end
        @(posedge clk); #2;
        chk("full_req_low", 32'(bus.mem_req),  32'd0);
        chk("full_valid",   32'(bus.ir_valid), 32'd1);
        chk("full_data",    32'(bus.ir_data),  32'h1000);
        chk("full_addr",    32'(bus.ir_addr),  32'h0000);

        // One pop from a full queue frees a slot for the next sequential word
        bus.ir_take = 1'b1;
        @(posedge clk); #1 bus.ir_take = 1'b0;
        #1;
        chk("pop_data",    32'(bus.ir_data), 32'h1002);
        chk("pop_addr",    32'(bus.ir_addr), 32'h0002);
        chk("pop_req_low", 32'(bus.mem_req), 32'd0);
        @(posedge clk); #2;
        chk("refill_req",  32'(bus.mem_req),  32'd1);
        chk("refill_addr", 32'(bus.mem_addr), 32'h0008);

        // Redirect while a slow read is in flight: request held, data dropped
        @(posedge clk); #1;
        ack_delay       = 3;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 16'h0000;
        @(posedge clk); #1 bus.redirect = 1'b0;
        wait_req("slow_req_seen");
        chk("slow_req_addr", 32'(bus.mem_addr), 32'h0000);
        @(posedge clk); #1;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 16'h0201;
        @(posedge clk); #1 bus.redirect = 1'b0;
        found = 1'b0;
        for (int n = 0; n < 10; n++) begin
            #1;
            chk("drain_req",  32'(bus.mem_req),  32'd1);
            chk("drain_addr", 32'(bus.mem_addr), 32'h0000);
            if (bus.mem_ack) begin found = 1'b1; break; end
            @(posedge clk); #1;
        end
        chk("drain_ack_seen", 32'(found), 32'd1);
        ack_delay = 0;
        wait_req("post_drain_req");
        chk("post_drain_addr", 32'(bus.mem_addr), 32'h0200);
        wait_valid("post_drain_valid");
        chk("post_drain_ir_addr", 32'(bus.ir_addr), 32'h0200);
        chk("post_drain_ir_data", 32'(bus.ir_data), 32'h1200);

        // Redirect together with a pop and a returning word
        found = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk); #2;
            if (bus.mem_req && bus.mem_ack && bus.ir_valid) begin found = 1'b1; break; end
        end
        chk("collide_setup", 32'(found), 32'd1);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 16'h0400;
        bus.ir_take     = 1'b1;
        @(posedge clk); #1;
        bus.redirect = 1'b0;
        bus.ir_take  = 1'b0;
        #1;
        chk("collide_empty",   32'(bus.ir_valid), 32'd0);
        chk("collide_req_low", 32'(bus.mem_req),  32'd0);
        wait_req("collide_req");
        chk("collide_addr", 32'(bus.mem_addr), 32'h0400);
        wait_valid("collide_valid");
        chk("collide_ir_addr", 32'(bus.ir_addr), 32'h0400);

        // Address wrap with a consumer taking every cycle: one word per cycle
        @(posedge clk); #1;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 16'hFFFC;
        bus.ir_take     = 1'b1;
        @(posedge clk); #1 bus.redirect = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #2;
            a = 16'hFFFC + 16'(2 * k);
            chk("wrap_req",  32'(bus.mem_req),  32'd1);
            chk("wrap_addr", 32'(bus.mem_addr), 32'(a));
            if (k >= 1) begin
                a = 16'hFFFC + 16'(2 * (k - 1));
                chk("wrap_ir_valid", 32'(bus.ir_valid), 32'd1);
                chk("wrap_ir_addr",  32'(bus.ir_addr),  32'(a));
            end
        end

        // Asynchronous reset in the middle of a request
        found = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk); #3;
            if (bus.mem_req) begin found = 1'b1; break; end
        end
        chk("arst_setup", 32'(found), 32'd1);
        rst_n       = 1'b0;
        bus.ir_take = 1'b0;
        #1;
        chk("arst_req_low",   32'(bus.mem_req),  32'd0);
        chk("arst_valid_low", 32'(bus.ir_valid), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #2;
        chk("arst_restart_req",  32'(bus.mem_req),  32'd1);
        chk("arst_restart_addr", 32'(bus.mem_addr), 32'h0000);

        // Randomized traffic against the reference model
        rand_ack = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            bus.ir_take     = ($urandom_range(0, 3) != 0);
            bus.redirect    = ($urandom_range(0, 39) == 0);
            bus.redirect_pc = 16'($urandom_range(0, 65535));
        end
        @(posedge clk); #1;
        bus.redirect = 1'b0;
        bus.ir_take  = 1'b0;
        repeat (6) @(posedge clk);
        #3;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
